rx_stream_arbiter: RTL and testbench
====================================

# rx_stream_arbiter

- Merges several show-ahead word sources into the single 32-bit stream that feeds the BRAM output FIFO (`ARB_DATA_OUT` / `ARB_WRITE_OUT` / `ARB_READY_OUT`).
- Typical sources are chip data RX, TLU trigger words and timestamp words.
- Grants sources round-robin, with a bounded burst hold so a busy source keeps the bus for up to `BURST_MAX` consecutive words.
- Registers the output word together with its source ID, and counts delivered words.

## Interface
Parameters:
- `CH`, 4, number of input channels (2..8).
- `DW`, 32, data word width.
- `BURST_MAX`, 16, maximum consecutive words granted to one channel. A value of 1 gives pure round-robin.

Ports:
- `BUS_CLK`  in  1  single clock for the whole block.
- `RESETB`  in  1  reset, asynchronous, active-low.
- `CH_EMPTY`  in  CH  per-channel empty flag; bit i low means `CH_DATA[i]` is valid (show-ahead).
- `CH_DATA`  in  CH*DW  packed channel words; channel i occupies `[i*DW +: DW]`.
- `CH_READ`  out  CH  one-hot pop strobe; the word is consumed in the same cycle.
- `ARB_READY_OUT`  in  1  downstream pop; effective only while `ARB_WRITE_OUT` is high.
- `ARB_WRITE_OUT`  out  1  output register holds a valid word.
- `ARB_DATA_OUT`  out  DW  output word.
- `ARB_SRC`  out  3  channel index of the word currently in `ARB_DATA_OUT`.
- `WORD_CNT`  out  32  number of words delivered downstream; wraps modulo 2^32.
- `ENABLE`  in  1  when low, no new grants are made. A word already in the output register still drains.

## Operation
- **Output register.** One entry holding `valid`, `data` and `src`.
  - It is free when `valid` is low, or when `ARB_READY_OUT & ARB_WRITE_OUT` holds in the same cycle. This gives full throughput of 1 word per cycle.
- **Grant.** Granting occurs only when the output register is free and `ENABLE` is high.
  - Candidates are all channels i with `CH_EMPTY[i]` low.
  - `CH_READ[i]` is asserted combinationally for the granted channel only. At most one bit of `CH_READ` is high at any time.
  - The granted word loads the output register at the next edge, with `src` set to i.
- **Arbitration state.** `last` holds the last granted channel (reset value `CH-1`, so channel 0 wins first). `burst` is a counter (reset value 0).
  - HOLD: if channel `last` is non-empty and `burst < BURST_MAX-1`, grant `last` again and increment `burst`.
  - ROTATE: otherwise, grant the first non-empty channel scanning `last+1, last+2, …` modulo CH. `last` wrapping to itself is allowed. Set `burst` to 0.
  - Leaving `last` for another channel always resets `burst`.
- **No candidates or disabled.** No grant; `last` and `burst` are unchanged.
- **`WORD_CNT`.** Increments on every cycle with `ARB_READY_OUT & ARB_WRITE_OUT`. It wraps 0xFFFFFFFF→0.
- **`ENABLE`.** Sampling is level-based; there is no pending grant when it falls.
- **Reset (asynchronous, including mid-burst).**
  - All outputs go to 0, and `CH_READ` goes to 0 combinationally.
  - `valid`=0, `last`=`CH-1`, `burst`=0, `WORD_CNT`=0.
  - Any word in the output register is dropped. Source FIFOs are not popped during reset.

## Timing
- Latency is 1 cycle from `CH_READ[i]` high to the word appearing on `ARB_DATA_OUT` with `ARB_WRITE_OUT` high.
- `CH_READ` depends combinationally on `CH_EMPTY`, `ARB_READY_OUT`, `ENABLE` and state. There is no combinational path from `CH_DATA` to any output.
- Steady state with downstream always ready: one word per cycle, with no bubble on channel switch.
- With `ARB_READY_OUT` low and `valid` high, `ARB_DATA_OUT`, `ARB_SRC` and `ARB_WRITE_OUT` are held stable and `CH_READ` is 0.
- A simultaneous consume and refill in one cycle is legal and required.

## Structure
- Shared package `tjmonopix2_arb_pkg` contains:
  - `CH_MAX`=8
  - `SRC_W`=3
  - the word-count width constant, 32.
- Sub-module `rr_pick`: purely combinational rotate-priority encoder.
  - Inputs: request vector and start index.
  - Outputs: one-hot grant and binary index.
  - It is instantiated once.
- All registers live in the top-level module.

## Test plan
- **Single source.** Channel 2 holds 5 words, `ARB_READY_OUT`=1. Expect the 5 words on consecutive cycles with `ARB_SRC`=2, no gaps, and `WORD_CNT`=5.
- **Pure round-robin.** `BURST_MAX`=1, channels 0 and 1 each hold 3 words. Expect source order 0,1,0,1,0,1.
- **Burst hold.** `BURST_MAX`=4, channel 0 holds 10 words, channel 3 holds 2 words. Expect source order 0,0,0,0,3,3,0,0,0,0,0,0.
- **Backpressure.** `ARB_READY_OUT` is low for 7 cycles while words are pending. Expect the output to stay frozen, `CH_READ`=0 throughout, and no word lost or duplicated; checked by scoreboard over 1000 random words.
- **Counter wrap.** Force `WORD_CNT`=0xFFFFFFFE, then deliver 3 words. Expect `WORD_CNT`=1.
- **Reset mid-burst.** Deassert `RESETB` during a channel-1 burst. Expect all outputs to go to 0 immediately. After release, the first grant goes to channel 0 when channels 0 and 1 are both non-empty.

Source files
------------

// File: rtl/tjmonopix2_arb_pkg.sv
// Shared constants and types for the RX stream arbiter and its priority picker.
package tjmonopix2_arb_pkg;

   localparam int CH_MAX = 8;
   localparam int SRC_W  = 3;
   localparam int CNT_W  = 32;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_HOLD,
      ARB_ROTATE
   } arb_op_e;

endpackage

// File: rtl/rx_stream_arbiter_rr_pick.sv
// Rotate-priority encoder: grants the first set request found scanning
// start, start+1, ... modulo N.
module rr_pick
   import tjmonopix2_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]     req,
   input  logic [SRC_W-1:0] start,
   output logic [N-1:0]     gnt,
   output logic [SRC_W-1:0] idx
);

   logic [CH_MAX-1:0] req_x;
   logic [SRC_W-1:0]  cand;

   assign req_x = CH_MAX'(req);

   // Walk the offsets backwards so the smallest offset from start wins.
   always_comb begin
      idx  = '0;
      cand = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = SRC_W'((int'(start) + k) % N);
         if (req_x[cand]) begin
            idx = cand;
         end
      end
   end

   always_comb begin
      gnt = '0;
      for (int i = 0; i < N; i++) begin
         gnt[i] = (|req) && (idx == SRC_W'(i));
      end
   end

endmodule

// File: rtl/rx_stream_arbiter.sv
// Round-robin merge of show-ahead word sources into one registered output
// stream, with bounded burst hold per source and a delivered-word counter.
module rx_stream_arbiter
   import tjmonopix2_arb_pkg::*;
#(
   parameter int CH        = 4,
   parameter int DW        = 32,
   parameter int BURST_MAX = 16
) (
   input  logic                BUS_CLK,
   input  logic                RESETB,
   input  logic [CH-1:0]       CH_EMPTY,
   input  logic [CH*DW-1:0]    CH_DATA,
   output logic [CH-1:0]       CH_READ,
   input  logic                ARB_READY_OUT,
   output logic                ARB_WRITE_OUT,
   output logic [DW-1:0]       ARB_DATA_OUT,
   output logic [SRC_W-1:0]    ARB_SRC,
   output logic [CNT_W-1:0]    WORD_CNT,
   input  logic                ENABLE
);

   localparam int BW = $clog2(BURST_MAX + 1);

   logic             valid_q, valid_d;
   logic [DW-1:0]    data_q,  data_d;
   logic [SRC_W-1:0] src_q,   src_d;
   logic [SRC_W-1:0] last_q,  last_d;
   logic [BW-1:0]    burst_q, burst_d;
   logic             held_q,  held_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic [CH_MAX-1:0] avail;
   logic [DW-1:0]     ch_word [CH_MAX];
   logic [CH-1:0]     pick_gnt;
   logic [SRC_W-1:0]  pick_idx;
   logic [SRC_W-1:0]  start;
   logic [SRC_W-1:0]  gnt_idx;
   logic [CH-1:0]     rd_oh;
   logic              free;
   logic              pop;
   logic              can_hold;
   arb_op_e           op;

   assign avail = CH_MAX'(~CH_EMPTY);

   for (genvar gi = 0; gi < CH_MAX; gi++) begin : g_word
      if (gi < CH) begin : g_live
         assign ch_word[gi] = CH_DATA[gi*DW +: DW];
      end else begin : g_pad
         assign ch_word[gi] = '0;
      end
   end

   rr_pick #(
      .N(CH)
   ) u_pick (
      .req   (~CH_EMPTY),
      .start (start),
      .gnt   (pick_gnt),
      .idx   (pick_idx)
   );

   always_comb begin
      free  = ~valid_q | ARB_READY_OUT;
      pop   = valid_q & ARB_READY_OUT;
      start = (last_q == SRC_W'(CH - 1)) ? '0 : last_q + SRC_W'(1);
      // Holding needs a real previous grant; right after reset `last` is only
      // a rotation seed, so channel 0 is reached first.
      can_hold = held_q && avail[last_q] && (int'(burst_q) < BURST_MAX - 1);

      op = ARB_IDLE;
      if (free && ENABLE && (|pick_gnt)) begin
         op = can_hold ? ARB_HOLD : ARB_ROTATE;
      end
      gnt_idx = (op == ARB_HOLD) ? last_q : pick_idx;

      rd_oh = '0;
      for (int i = 0; i < CH; i++) begin
         rd_oh[i] = (op != ARB_IDLE) && (gnt_idx == SRC_W'(i));
      end

      valid_d = valid_q & ~pop;
      data_d  = data_q;
      src_d   = src_q;
      last_d  = last_q;
      burst_d = burst_q;
      held_d  = held_q;
      cnt_d   = pop ? cnt_q + CNT_W'(1) : cnt_q;

      if (op != ARB_IDLE) begin
         valid_d = 1'b1;
         data_d  = ch_word[gnt_idx];
         src_d   = gnt_idx;
         last_d  = gnt_idx;
         held_d  = 1'b1;
         burst_d = (op == ARB_HOLD) ? burst_q + BW'(1) : '0;
      end
   end

   always_ff @(posedge BUS_CLK or negedge RESETB) begin
      if (!RESETB) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= '0;
         last_q  <= SRC_W'(CH - 1);
         burst_q <= '0;
         held_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         src_q   <= src_d;
         last_q  <= last_d;
         burst_q <= burst_d;
         held_q  <= held_d;
         cnt_q   <= cnt_d;
      end
   end

   // Sources must never be popped while reset is held.
   assign CH_READ       = rd_oh & {CH{RESETB}};
   assign ARB_WRITE_OUT = valid_q;
   assign ARB_DATA_OUT  = data_q;
   assign ARB_SRC       = src_q;
   assign WORD_CNT      = cnt_q;

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Directed bench: three arbiter instances (BURST_MAX 16, 1, 4) fed by queue
// models of show-ahead FIFOs, with a per-channel scoreboard on every delivery.
module tb_rx_stream_arbiter;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;

   logic [3:0]   empty [3];
   logic [127:0] data  [3];
   logic         ready [3];
   logic         enable[3];
   logic [3:0]   rd    [3];
   logic         wr    [3];
   logic [31:0]  dout  [3];
   logic [2:0]   src   [3];
   logic [31:0]  cnt   [3];

   logic [31:0] fq      [3][4][$];
   logic [31:0] sb      [3][4][$];
   logic [2:0]  got_src [3][$];

   int vectors     = 0;
   int miscompares = 0;

   int exp_b [12] = '{0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0};

   always #5 clk = ~clk;

   rx_stream_arbiter #(.CH(4), .DW(32), .BURST_MAX(16)) u_dut0 (
      .BUS_CLK(clk), .RESETB(rst_n), .CH_EMPTY(empty[0]), .CH_DATA(data[0]),
      .CH_READ(rd[0]), .ARB_READY_OUT(ready[0]), .ARB_WRITE_OUT(wr[0]),
      .ARB_DATA_OUT(dout[0]), .ARB_SRC(src[0]), .WORD_CNT(cnt[0]), .ENABLE(enable[0])
   );

   rx_stream_arbiter #(.CH(4), .DW(32), .BURST_MAX(1)) u_dut1 (
      .BUS_CLK(clk), .RESETB(rst_n), .CH_EMPTY(empty[1]), .CH_DATA(data[1]),
      .CH_READ(rd[1]), .ARB_READY_OUT(ready[1]), .ARB_WRITE_OUT(wr[1]),
      .ARB_DATA_OUT(dout[1]), .ARB_SRC(src[1]), .WORD_CNT(cnt[1]), .ENABLE(enable[1])
   );

   rx_stream_arbiter #(.CH(4), .DW(32), .BURST_MAX(4)) u_dut2 (
      .BUS_CLK(clk), .RESETB(rst_n), .CH_EMPTY(empty[2]), .CH_DATA(data[2]),
      .CH_READ(rd[2]), .ARB_READY_OUT(ready[2]), .ARB_WRITE_OUT(wr[2]),
      .ARB_DATA_OUT(dout[2]), .ARB_SRC(src[2]), .WORD_CNT(cnt[2]), .ENABLE(enable[2])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < 4; c++) begin
            empty[k][c] = (fq[k][c].size() == 0);
            data[k][c*32 +: 32] = (fq[k][c].size() == 0) ? 32'h0 : fq[k][c][0];
         end
      end
   endtask

   task automatic push_word(input int k, input int c, input logic [31:0] w);
      fq[k][c].push_back(w);
      sb[k][c].push_back(w);
   endtask

   task automatic clear_all();
      for (int k = 0; k < 3; k++) begin
         got_src[k].delete();
         for (int c = 0; c < 4; c++) begin
            fq[k][c].delete();
            sb[k][c].delete();
         end
      end
      refresh();
   endtask

   // One clock: score what the DUTs hand over, let the edge happen, then pop
   // the source FIFOs that were strobed and present their new heads.
   task automatic tick();
      logic [3:0] rd_s [3];
      logic [2:0] s;
      #1;
      for (int k = 0; k < 3; k++) begin
         rd_s[k] = rd[k];
         check("rd_onehot", {31'b0, $onehot0(rd[k])}, 32'd1);
         check("rd_on_empty", {28'b0, rd[k] & empty[k]}, 32'd0);
         if (wr[k] && ready[k]) begin
            s = src[k];
            got_src[k].push_back(s);
            if (s > 3 || sb[k][s].size() == 0) check("sb_extra_word", {29'b0, s}, 32'hFFFF_FFFF);
            else check("sb_data", dout[k], sb[k][s].pop_front());
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < 4; c++) begin
            if (rd_s[k][c] && fq[k][c].size() > 0) void'(fq[k][c].pop_front());
         end
      end
      refresh();
      #1;
   endtask

   initial begin
      logic [31:0] snap_d;
      logic [2:0]  snap_s;
      int          cyc;
      int          left;

      for (int k = 0; k < 3; k++) begin
         ready[k]  = 1'b1;
         enable[k] = 1'b1;
      end
      clear_all();
      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_write", {31'b0, wr[0]}, 32'd0);
      check("rst_data", dout[0], 32'd0);
      check("rst_src", {29'b0, src[0]}, 32'd0);
      check("rst_cnt", cnt[0], 32'd0);
      check("rst_read", {28'b0, rd[0]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single source: channel 2, five back-to-back words.
      for (int i = 0; i < 5; i++) push_word(0, 2, 32'hA000_0000 + i);
      refresh();
      #1;
      check("single_first_read", {28'b0, rd[0]}, 32'h4);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("single_write", {31'b0, wr[0]}, 32'd1);
         check("single_src", {29'b0, src[0]}, 32'd2);
         check("single_data", dout[0], 32'hA000_0000 + i);
      end
      tick();
      check("single_drained", {31'b0, wr[0]}, 32'd0);
      check("single_cnt", cnt[0], 32'd5);

      // Pure round-robin on the BURST_MAX=1 instance.
      for (int i = 0; i < 3; i++) begin
         push_word(1, 0, 32'hB000_0000 + i);
         push_word(1, 1, 32'hB100_0000 + i);
      end
      refresh();
      cyc = 0;
      while (got_src[1].size() < 6 && cyc < 30) begin
         tick();
         cyc++;
      end
      check("rr_count", got_src[1].size(), 32'd6);
      for (int j = 0; j < 6; j++) begin
         check("rr_src", (j < got_src[1].size()) ? {29'b0, got_src[1][j]} : 32'hDEAD, j % 2);
      end
      check("rr_cnt", cnt[1], 32'd6);

      // Burst hold on the BURST_MAX=4 instance.
      for (int i = 0; i < 10; i++) push_word(2, 0, 32'hC000_0000 + i);
      for (int i = 0; i < 2; i++) push_word(2, 3, 32'hC300_0000 + i);
      refresh();
      cyc = 0;
      while (got_src[2].size() < 12 && cyc < 40) begin
         tick();
         cyc++;
      end
      check("burst_count", got_src[2].size(), 32'd12);
      for (int j = 0; j < 12; j++) begin
         check("burst_src", (j < got_src[2].size()) ? {29'b0, got_src[2][j]} : 32'hDEAD, exp_b[j]);
      end

      // Backpressure with 1000 random words and a 7-cycle stall.
      clear_all();
      for (int i = 0; i < 1000; i++) push_word(0, $urandom_range(0, 3), $urandom);
      refresh();
      cyc = 0;
      while (got_src[0].size() < 1000 && cyc < 5000) begin
         ready[0] = (cyc >= 20 && cyc < 27) ? 1'b0 : ($urandom_range(0, 3) != 0);
         #1;
         if (cyc == 20) begin
            snap_d = dout[0];
            snap_s = src[0];
            check("bp_holding", {31'b0, wr[0]}, 32'd1);
         end
         if (cyc >= 20 && cyc < 27) check("bp_read_zero", {28'b0, rd[0]}, 32'd0);
         tick();
         if (cyc >= 20 && cyc < 27) begin
            check("bp_write_held", {31'b0, wr[0]}, 32'd1);
            check("bp_data_held", dout[0], snap_d);
            check("bp_src_held", {29'b0, src[0]}, {29'b0, snap_s});
         end
         cyc++;
      end
      check("bp_delivered", got_src[0].size(), 32'd1000);
      check("bp_cnt", cnt[0], 32'd1005);
      left = 0;
      for (int c = 0; c < 4; c++) left += sb[0][c].size();
      check("bp_left", left, 32'd0);

      // Counter wrap.
      ready[0] = 1'b0;
      clear_all();
      @(negedge clk);
      force u_dut0.cnt_d = 32'hFFFF_FFFE;
      @(posedge clk);
      #1;
      release u_dut0.cnt_d;
      #1;
      check("wrap_preset", cnt[0], 32'hFFFF_FFFE);
      for (int i = 0; i < 3; i++) push_word(0, 1, 32'hE000_0000 + i);
      refresh();
      ready[0] = 1'b1;
      repeat (5) tick();
      check("wrap_cnt", cnt[0], 32'd1);

      // Reset in the middle of a channel-1 burst.
      clear_all();
      for (int i = 0; i < 8; i++) push_word(0, 1, 32'hF100_0000 + i);
      refresh();
      repeat (3) tick();
      check("mid_burst_src", {29'b0, src[0]}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_write", {31'b0, wr[0]}, 32'd0);
      check("mid_rst_data", dout[0], 32'd0);
      check("mid_rst_src", {29'b0, src[0]}, 32'd0);
      check("mid_rst_cnt", cnt[0], 32'd0);
      check("mid_rst_read", {28'b0, rd[0]}, 32'd0);
      clear_all();
      for (int i = 0; i < 8; i++) push_word(0, 1, 32'hF100_0000 + i);
      refresh();
      repeat (2) tick();
      check("rst_no_pop", fq[0][1].size(), 32'd8);
      rst_n = 1'b1;
      push_word(0, 0, 32'hD000_0000);
      refresh();
      #1;
      check("post_rst_read", {28'b0, rd[0]}, 32'h1);
      tick();
      check("post_rst_write", {31'b0, wr[0]}, 32'd1);
      check("post_rst_src", {29'b0, src[0]}, 32'd0);
      check("post_rst_data", dout[0], 32'hD000_0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
